// File: rtl/mem_arbiter.sv
// Two-port round-robin memory bus arbiter with bounded-wait abort.
// One requester owns the bus per grant; an IDLE cycle separates grants.
module mem_arbiter #(
  parameter int WIDTH   = 16,
  parameter int TIMEOUT = 255,
  parameter int TO_BITS = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req0_read,
  input  logic             req0_write,
  input  logic [WIDTH-1:0] req0_addr,
  input  logic [WIDTH-1:0] req0_wdata,
  output logic             ack0,
  input  logic             req1_read,
  input  logic             req1_write,
  input  logic [WIDTH-1:0] req1_addr,
  input  logic [WIDTH-1:0] req1_wdata,
  output logic             ack1,
  output logic [WIDTH-1:0] rdata,
  output logic             mem_read,
  output logic             mem_write,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic             mem_ack,
  input  logic [WIDTH-1:0] mem_rdata,
  output logic [1:0]       grant,
  output logic [1:0]       state,
  output logic             timeout_err
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2,
    UNUSED = 2'd3
  } state_t;

  localparam logic [TO_BITS-1:0] TO_VAL = TO_BITS'(TIMEOUT);

  state_t             r_state, w_state_next;
  logic               r_last, w_last_next;
  logic [TO_BITS-1:0] r_cnt, w_cnt_next;
  logic               r_to_err, w_to_err_next;

  logic               w_v0, w_v1;
  logic               w_granted, w_port;
  logic               w_sel_rd, w_sel_wr, w_sel_valid;
  logic [WIDTH-1:0]   w_sel_addr, w_sel_wdata;

  assign w_v0 = req0_read | req0_write;
  assign w_v1 = req1_read | req1_write;

  // Granted-port input mux; shared by both GRANT states.
  assign w_granted   = (r_state == GRANT0) || (r_state == GRANT1);
  assign w_port      = (r_state == GRANT1);
  assign w_sel_rd    = w_port ? req1_read  : req0_read;
  assign w_sel_wr    = w_port ? req1_write : req0_write;
  assign w_sel_addr  = w_port ? req1_addr  : req0_addr;
  assign w_sel_wdata = w_port ? req1_wdata : req0_wdata;
  assign w_sel_valid = w_sel_rd | w_sel_wr;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state  <= IDLE;
      r_last   <= 1'b1;
      r_cnt    <= '0;
      r_to_err <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_last   <= w_last_next;
      r_cnt    <= w_cnt_next;
      r_to_err <= w_to_err_next;
    end
  end

  always_comb begin
    w_state_next  = r_state;
    w_last_next   = r_last;
    w_cnt_next    = r_cnt;
    w_to_err_next = 1'b0;
    case (r_state)
      IDLE: begin
        w_cnt_next = '0;
        if (w_v0 && w_v1)
          w_state_next = r_last ? GRANT0 : GRANT1;
        else if (w_v0)
          w_state_next = GRANT0;
        else if (w_v1)
          w_state_next = GRANT1;
      end
      GRANT0, GRANT1: begin
        if (mem_ack) begin
          w_state_next = IDLE;
          w_last_next  = w_port;
        end else if (!w_sel_valid) begin
          w_state_next = IDLE;
        end else if (r_cnt == TO_VAL) begin
          // Abort but record this port as the winner so a waiting peer goes first.
          w_state_next  = IDLE;
          w_last_next   = w_port;
          w_to_err_next = 1'b1;
        end else if (r_cnt != {TO_BITS{1'b1}}) begin
          w_cnt_next = r_cnt + TO_BITS'(1);
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  assign mem_write   = w_granted & w_sel_wr;
  assign mem_read    = w_granted & w_sel_rd & ~w_sel_wr;
  assign mem_addr    = w_granted ? w_sel_addr  : '0;
  assign mem_wdata   = w_granted ? w_sel_wdata : '0;
  assign ack0        = (r_state == GRANT0) & mem_ack;
  assign ack1        = (r_state == GRANT1) & mem_ack;
  assign rdata       = mem_rdata;
  assign grant       = {r_state == GRANT1, r_state == GRANT0};
  assign state       = r_state;
  assign timeout_err = r_to_err;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus a randomized phase, every
// cycle compared against a transaction-level ownership model.
module tb_mem_arbiter;
  localparam int W  = 16;
  localparam int TO = 4;

  logic          clock = 1'b0;
  logic          reset;
  logic          req0_read, req0_write, req1_read, req1_write;
  logic [W-1:0]  req0_addr, req0_wdata, req1_addr, req1_wdata;
  logic          ack0, ack1;
  logic [W-1:0]  rdata, mem_addr, mem_wdata, mem_rdata;
  logic          mem_read, mem_write, mem_ack;
  logic [1:0]    grant, state;
  logic          timeout_err;

  mem_arbiter #(.WIDTH(W), .TIMEOUT(TO), .TO_BITS(8)) dut (
    .clock(clock), .reset(reset),
    .req0_read(req0_read), .req0_write(req0_write), .req0_addr(req0_addr),
    .req0_wdata(req0_wdata), .ack0(ack0),
    .req1_read(req1_read), .req1_write(req1_write), .req1_addr(req1_addr),
    .req1_wdata(req1_wdata), .ack1(ack1),
    .rdata(rdata), .mem_read(mem_read), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .grant(grant), .state(state),
    .timeout_err(timeout_err)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;

  // Ownership model: -1 = bus free, else owning port; cycles waited; last winner.
  int   m_owner;
  int   m_wait;
  bit   m_last;
  bit   m_err;

  // Scenario controls: ack_lat >=0 fixed latency, -1 never, -2 random.
  int          ack_lat;
  bit          idle_noise, rnd_mode, rereq, fix_rdata;
  logic [W-1:0] fixed_val;

  int          cyc, n_ack0, n_ack1, n_err, n_strobe1, first_strobe;
  int          ack_cyc_q[$];
  int          gq[$];
  logic [31:0] wlog[$];
  logic [W-1:0] rdata_at_ack;
  logic [1:0]  prev_grant;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_owner = -1; m_wait = 0; m_last = 1'b1; m_err = 1'b0;
  endtask

  task automatic clear_stats();
    cyc = 0; n_ack0 = 0; n_ack1 = 0; n_err = 0; n_strobe1 = 0; first_strobe = -1;
    ack_cyc_q.delete(); gq.delete(); wlog.delete();
    rdata_at_ack = '0;
  endtask

  task automatic drop_req(input int p);
    if (p == 0) begin req0_read = 0; req0_write = 0; end
    else        begin req1_read = 0; req1_write = 0; end
  endtask

  task automatic new_req(input int p, input bit rd_only);
    logic [1:0] t;
    t = rd_only ? 2'b01 : 2'($urandom_range(1, 3));
    if (p == 0) begin
      req0_read = t[0]; req0_write = t[1];
      req0_addr = 16'($urandom); req0_wdata = 16'($urandom);
    end else begin
      req1_read = t[0]; req1_write = t[1];
      req1_addr = 16'($urandom); req1_wdata = 16'($urandom);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drop_req(0); drop_req(1);
    req0_addr = '0; req0_wdata = '0; req1_addr = '0; req1_wdata = '0;
    mem_ack = 0; mem_rdata = '0;
    ack_lat = 0; idle_noise = 0; rnd_mode = 0; rereq = 0; fix_rdata = 0;
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    model_reset();
    prev_grant = 2'b00;
    clear_stats();
  endtask

  // One bus cycle: entered at negedge with inputs set, leaves at the next negedge.
  task automatic cycle();
    logic       e_rd, e_wr, e_a0, e_a1;
    logic [W-1:0] e_addr, e_wd;
    logic [1:0] e_gr, e_st;
    bit         acked0, acked1, v0, v1, vp, a, v, err_n;
    int         p;
    if (m_owner >= 0) begin
      if (ack_lat == -2) mem_ack = ($urandom_range(0, 3) == 0);
      else               mem_ack = (ack_lat >= 0) && (m_wait >= ack_lat);
    end else begin
      mem_ack = idle_noise ? 1'($urandom_range(0, 1)) : 1'b0;
    end
    mem_rdata = fix_rdata ? fixed_val : 16'($urandom);
    #1;
    e_rd = 0; e_wr = 0; e_a0 = 0; e_a1 = 0; e_addr = '0; e_wd = '0;
    if (m_owner == 0) begin
      e_wr = req0_write; e_rd = req0_read & ~req0_write;
      e_addr = req0_addr; e_wd = req0_wdata; e_a0 = mem_ack;
    end else if (m_owner == 1) begin
      e_wr = req1_write; e_rd = req1_read & ~req1_write;
      e_addr = req1_addr; e_wd = req1_wdata; e_a1 = mem_ack;
    end
    e_st = (m_owner < 0) ? 2'd0 : 2'(m_owner + 1);
    e_gr = (m_owner == 0) ? 2'b01 : (m_owner == 1) ? 2'b10 : 2'b00;
    chk("state", state, e_st);
    chk("grant", grant, e_gr);
    chk("mem_read", mem_read, e_rd);
    chk("mem_write", mem_write, e_wr);
    chk("mem_addr", mem_addr, e_addr);
    chk("mem_wdata", mem_wdata, e_wd);
    chk("ack0", ack0, e_a0);
    chk("ack1", ack1, e_a1);
    chk("timeout_err", timeout_err, m_err);
    chk("rdata", rdata, mem_rdata);
    if (ack0) begin n_ack0++; ack_cyc_q.push_back(cyc); rdata_at_ack = rdata; end
    if (ack1) begin n_ack1++; ack_cyc_q.push_back(cyc); end
    if (timeout_err) n_err++;
    if (grant == 2'b10 && mem_read) n_strobe1++;
    if (first_strobe < 0 && (mem_read || mem_write)) first_strobe = cyc;
    if (mem_write && mem_ack) wlog.push_back({mem_addr, mem_wdata});
    if (prev_grant == 2'b00 && grant != 2'b00) gq.push_back((grant == 2'b10) ? 1 : 0);
    prev_grant = grant;

    @(posedge clock);
    v0 = req0_read | req0_write;
    v1 = req1_read | req1_write;
    acked0 = 0; acked1 = 0; err_n = 0;
    if (m_owner < 0) begin
      m_wait = 0;
      if (v0 && v1)  m_owner = m_last ? 0 : 1;
      else if (v0)   m_owner = 0;
      else if (v1)   m_owner = 1;
    end else begin
      p  = m_owner;
      vp = (p == 1) ? v1 : v0;
      if (mem_ack) begin
        if (p == 0) acked0 = 1; else acked1 = 1;
        m_last = (p == 1); m_owner = -1;
      end else if (!vp) begin
        m_owner = -1;
      end else if (m_wait == TO) begin
        m_last = (p == 1); m_owner = -1; err_n = 1;
      end else begin
        m_wait++;
      end
    end
    m_err = err_n;

    @(negedge clock);
    cyc++;
    for (int q = 0; q < 2; q++) begin
      a = (q == 0) ? acked0 : acked1;
      v = (q == 0) ? (req0_read | req0_write) : (req1_read | req1_write);
      if (a) begin
        drop_req(q);
        if (rereq) new_req(q, 1'b1);
        else if (rnd_mode && $urandom_range(0, 1) == 0) new_req(q, 1'b0);
      end else if (rnd_mode) begin
        if (v && $urandom_range(0, 15) == 0) drop_req(q);
        else if (!v && $urandom_range(0, 3) == 0) new_req(q, 1'b0);
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    req0_read = 0; req0_write = 0; req1_read = 0; req1_write = 0;
    req0_addr = '0; req0_wdata = '0; req1_addr = '0; req1_wdata = '0;
    mem_ack = 0; mem_rdata = '0;
    #1;
    chk("rst_state", state, 2'd0);
    chk("rst_grant", grant, 2'b00);
    chk("rst_strobes", {mem_read, mem_write, ack0, ack1, timeout_err}, 5'b0);
    chk("rst_addr", {mem_addr, mem_wdata}, 32'h0);

    // Single read on port 0, ack one cycle after the strobe.
    do_reset();
    req0_read = 1; req0_addr = 16'h0010; ack_lat = 1; fix_rdata = 1; fixed_val = 16'hBEEF;
    for (int i = 0; i < 4; i++) cycle();
    chk("rd_first_strobe", first_strobe, 1);
    chk("rd_ack_count", ack_cyc_q.size(), 1);
    if (ack_cyc_q.size() > 0) chk("rd_ack_cycle", ack_cyc_q[0], 2);
    chk("rd_rdata", rdata_at_ack, 16'hBEEF);
    chk("rd_no_ack1", n_ack1, 0);
    #1 chk("rd_final_state", state, 2'd0);

    // Simultaneous writes after reset, immediate ack.
    do_reset();
    req0_write = 1; req0_addr = 16'h0001; req0_wdata = 16'h1111;
    req1_write = 1; req1_addr = 16'h0002; req1_wdata = 16'h2222;
    ack_lat = 0;
    for (int i = 0; i < 5; i++) cycle();
    chk("wr_count", wlog.size(), 2);
    if (wlog.size() == 2) begin
      chk("wr_first", wlog[0], 32'h0001_1111);
      chk("wr_second", wlog[1], 32'h0002_2222);
    end
    chk("wr_ack_count", ack_cyc_q.size(), 2);
    if (ack_cyc_q.size() == 2) begin
      chk("wr_ack_cyc0", ack_cyc_q[0], 1);
      chk("wr_ack_cyc1", ack_cyc_q[1], 3);
    end

    // Fairness: both ports keep reading.
    do_reset();
    new_req(0, 1'b1); new_req(1, 1'b1); rereq = 1; ack_lat = 0;
    for (int i = 0; i < 40 && (n_ack0 + n_ack1) < 6; i++) cycle();
    chk("fair_ack0", n_ack0, 3);
    chk("fair_ack1", n_ack1, 3);
    chk("fair_grants", gq.size() >= 6, 1);
    for (int i = 0; i < 6 && i < gq.size(); i++) chk($sformatf("fair_seq%0d", i), gq[i], i % 2);
    rereq = 0;

    // Timeout on port 1 with port 0 pending.
    do_reset();
    req1_read = 1; req1_addr = 16'h0ABC; ack_lat = -1;
    cycle();
    req0_read = 1; req0_addr = 16'h0123;
    for (int i = 0; i < 20 && gq.size() < 2; i++) cycle();
    chk("to_strobe_cycles", n_strobe1, TO + 1);
    chk("to_err_pulses", n_err, 1);
    chk("to_no_ack1", n_ack1, 0);
    chk("to_grants", gq.size(), 2);
    if (gq.size() == 2) begin
      chk("to_first", gq[0], 1);
      chk("to_next", gq[1], 0);
    end

    // Read+write on port 0, then request dropped while granted.
    do_reset();
    req0_read = 1; req0_write = 1; req0_addr = 16'h0055; req0_wdata = 16'h6677; ack_lat = -1;
    cycle();
    #1;
    chk("rw_write", mem_write, 1'b1);
    chk("rw_read", mem_read, 1'b0);
    drop_req(0);
    cycle();
    cycle();
    chk("drop_no_ack", n_ack0, 0);
    chk("drop_no_err", n_err, 0);
    #1 chk("drop_state", state, 2'd0);

    // Asynchronous reset mid-GRANT1.
    do_reset();
    req1_write = 1; req1_addr = 16'h0777; req1_wdata = 16'h8888; ack_lat = -1;
    cycle();
    cycle();
    #1 chk("arst_pre_write", mem_write, 1'b1);
    #1 reset = 1'b1;
    #1;
    chk("arst_write", mem_write, 1'b0);
    chk("arst_grant", grant, 2'b00);
    chk("arst_state", state, 2'd0);
    chk("arst_ack1", ack1, 1'b0);
    @(negedge clock);
    reset = 1'b0;
    model_reset();
    prev_grant = 2'b00;
    clear_stats();
    req0_read = 1; req0_addr = 16'h0042; ack_lat = 0;
    for (int i = 0; i < 5 && gq.size() < 1; i++) cycle();
    chk("arst_tie_n", gq.size(), 1);
    if (gq.size() > 0) chk("arst_tie", gq[0], 0);

    // Randomized traffic against the ownership model.
    do_reset();
    rnd_mode = 1; ack_lat = -2; idle_noise = 1;
    for (int i = 0; i < 400; i++) cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
